// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one stb/ack floating-point multiplier between N requesters.
// One operation is in flight at a time; the product returns on a one-hot response channel.
module mul_arbiter #(
  parameter int N     = 4,
  parameter int N_LEN = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       rsp_z,
  output logic [N-1:0]      rsp_valid,
  input  logic [N-1:0]      rsp_ack,
  output logic [N_LEN-1:0]  grant,
  output logic              busy,
  output logic              mul_rst,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  output logic              mul_a_stb,
  output logic              mul_b_stb,
  input  logic              mul_a_ack,
  input  logic              mul_b_ack,
  input  logic [31:0]       mul_z,
  input  logic              mul_z_stb,
  output logic              mul_z_ack
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [N_LEN-1:0]   last_q, last_d;
  logic [N_LEN-1:0]   grant_q, grant_d;
  logic [N-1:0]       req_ready_q, req_ready_d;
  logic [N-1:0]       rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_z_q, rsp_z_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               mul_a_stb_q, mul_a_stb_d;
  logic               mul_b_stb_q, mul_b_stb_d;
  logic               mul_z_ack_q, mul_z_ack_d;
  logic               mul_rst_q, mul_rst_d;

  logic               hi_found, lo_found, win_found;
  logic [N_LEN-1:0]   hi_idx, lo_idx, win_idx;
  logic [31:0]        win_a, win_b;

  // Winner search starts just above last: the lowest requester above last wins,
  // otherwise the lowest requester at or below last (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = N_LEN'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = N_LEN'(i);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == N_LEN'(i)) begin
        win_a = req_a[i*32 +: 32];
        win_b = req_b[i*32 +: 32];
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_a_stb_d = mul_a_stb_q;
    mul_b_stb_d = mul_b_stb_q;
    mul_z_ack_d = 1'b0;
    mul_rst_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The edge that releases the multiplier reset never carries a grant.
        if (win_found && !mul_rst_q) begin
          grant_d     = win_idx;
          mul_a_d     = win_a;
          mul_b_d     = win_b;
          req_ready_d = N'(1) << win_idx;
          mul_a_stb_d = 1'b1;
          state_d     = SEND_A;
        end
      end
      SEND_A: begin
        if (mul_a_ack) begin
          mul_a_stb_d = 1'b0;
          mul_b_stb_d = 1'b1;
          state_d     = SEND_B;
        end
      end
      SEND_B: begin
        if (mul_b_ack) begin
          mul_b_stb_d = 1'b0;
          state_d     = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (mul_z_stb) begin
          rsp_z_d     = mul_z;
          mul_z_ack_d = 1'b1;
          rsp_valid_d = N'(1) << grant_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        // rsp_valid_q is one-hot on the grant, so this masks off other lanes' acks.
        if (|(rsp_ack & rsp_valid_q)) begin
          rsp_valid_d = '0;
          last_d      = grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= N_LEN'(N - 1);
      grant_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_a_stb_q <= 1'b0;
      mul_b_stb_q <= 1'b0;
      mul_z_ack_q <= 1'b0;
      mul_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_a_stb_q <= mul_a_stb_d;
      mul_b_stb_q <= mul_b_stb_d;
      mul_z_ack_q <= mul_z_ack_d;
      mul_rst_q   <= mul_rst_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign mul_rst   = mul_rst_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_a_stb = mul_a_stb_q;
  assign mul_b_stb = mul_b_stb_q;
  assign mul_z_ack = mul_z_ack_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a stb/ack multiplier stub with random latency, a round-robin
// reference model over a plain integer 'last', and scenario tasks run in sequence.
module tb_mul_arbiter;
  localparam int N  = 4;
  localparam int NL = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0][31:0]  opa, opb;
  logic [N*32-1:0]     req_a, req_b;
  logic [N-1:0]        req_ready;
  logic [31:0]         rsp_z;
  logic [N-1:0]        rsp_valid;
  logic [N-1:0]        rsp_ack;
  logic [NL-1:0]       grant;
  logic                busy, mul_rst;
  logic [31:0]         mul_a, mul_b;
  logic                mul_a_stb, mul_b_stb;
  logic                mul_a_ack, mul_b_ack;
  logic [31:0]         mul_z;
  logic                mul_z_stb, mul_z_ack;

  int checks   = 0;
  int failures = 0;
  int model_last;

  // Multiplier stub state and stray-handshake injectors.
  logic a_ack_r = 1'b0, b_ack_r = 1'b0, z_real = 1'b0, z_pend = 1'b0, prev_z_ack = 1'b0;
  logic force_a_ack = 1'b0, force_z_stb = 1'b0, hold_b_ack = 1'b0;
  int   z_cnt = 0, fixed_lat = -1;
  logic [31:0] st_a = '0, st_b = '0;

  assign req_a     = opa;
  assign req_b     = opb;
  assign mul_a_ack = a_ack_r | force_a_ack;
  assign mul_b_ack = b_ack_r;
  assign mul_z_stb = z_real | force_z_stb;

  always #5 clk = ~clk;

  mul_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_z(rsp_z), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .grant(grant), .busy(busy), .mul_rst(mul_rst),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack)
  );

  // Exact single-precision product for normal operands with short mantissas.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    logic [9:0] m;
    e = 8'(100 + $urandom_range(0, 50));
    m = 10'($urandom);
    return {1'($urandom), e, m, 13'b0};
  endfunction

  // Round robin: first valid index among last+1, last+2, ... modulo N.
  function automatic int model_pick(input logic [N-1:0] v, input int last);
    logic [NL-1:0] idx;
    for (int k = 1; k <= N; k++) begin
      idx = NL'((last + k) % N);
      if (v[idx]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Stub multiplier plus protocol monitors; inputs change on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((rsp_valid & req_ready) != 0 || $countones(rsp_valid) > 1 || $countones(req_ready) > 1) begin
        failures++;
        $display("FAIL onehot_overlap rsp_valid=%b req_ready=%b", rsp_valid, req_ready);
      end
      checks++;
      if ((a_ack_r && mul_a_stb) || (b_ack_r && mul_b_stb)) begin
        failures++;
        $display("FAIL strobe_after_ack a_stb=%b b_stb=%b expected both low", mul_a_stb, mul_b_stb);
      end
      checks++;
      if (mul_z_ack && (!z_real || prev_z_ack)) begin
        failures++;
        $display("FAIL z_ack_pulse z_ack=1 real_stb=%b prev_ack=%b expected ack only once on a real strobe",
                 z_real, prev_z_ack);
      end
    end
    prev_z_ack = mul_z_ack;
    if (mul_rst !== 1'b0) begin
      a_ack_r = 1'b0;
      b_ack_r = 1'b0;
      z_real  = 1'b0;
      z_pend  = 1'b0;
    end else begin
      a_ack_r = mul_a_stb;
      if (mul_a_stb) st_a = mul_a;
      if (z_real) begin
        if (mul_z_ack) z_real = 1'b0;
      end else if (z_pend) begin
        if (z_cnt == 0) begin
          z_real = 1'b1;
          z_pend = 1'b0;
          mul_z  = fp_mul(st_a, st_b);
        end else begin
          z_cnt--;
        end
      end
      b_ack_r = mul_b_stb && !hold_b_ack;
      if (b_ack_r) begin
        st_b   = mul_b;
        z_pend = 1'b1;
        z_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
    end
  end

  // Serves the next grant predicted by the model; returns grant, product and wait cycles.
  task automatic serve_one(input int hold, input logic [N-1:0] stray, input bit drop, input bit scramble,
                           output int got_g, output logic [31:0] got_z, output int lat);
    int            exp_g, t;
    logic [NL-1:0] gi;
    logic [N-1:0]  oh;
    logic [31:0]   exp_z;
    exp_g = model_pick(req_valid, model_last);
    got_g = -1;
    got_z = '0;
    t = 0;
    while (req_ready == 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    lat = t;
    checks++;
    if (t >= 50 || exp_g < 0) begin
      failures++;
      $display("FAIL ready_timeout waited=%0d cycles expected grant %0d", t, exp_g);
      return;
    end
    gi = NL'(exp_g);
    oh = '0;
    oh[gi] = 1'b1;
    checks++;
    if (req_ready !== oh || grant !== gi || mul_a_stb !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL grant req_ready=%b grant=%0d a_stb=%b busy=%b expected ready=%b grant=%0d",
               req_ready, grant, mul_a_stb, busy, oh, gi);
    end
    checks++;
    if (mul_a !== opa[gi] || mul_b !== opb[gi]) begin
      failures++;
      $display("FAIL operands mul_a=%h mul_b=%h expected %h %h", mul_a, mul_b, opa[gi], opb[gi]);
    end
    exp_z = fp_mul(opa[gi], opb[gi]);
    if (drop) req_valid[gi] = 1'b0;
    if (scramble) begin
      opa[gi] = rand_fp();
      opb[gi] = rand_fp();
    end
    t = 0;
    while (rsp_valid == 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 100) begin
      failures++;
      $display("FAIL rsp_timeout waited=%0d cycles for lane %0d", t, exp_g);
      return;
    end
    checks++;
    if (rsp_valid !== oh || rsp_z !== exp_z || mul_z_ack !== 1'b1 || grant !== gi) begin
      failures++;
      $display("FAIL response rsp_valid=%b rsp_z=%h z_ack=%b grant=%0d expected %b %h 1 %0d",
               rsp_valid, rsp_z, mul_z_ack, grant, oh, exp_z, gi);
    end
    got_g = exp_g;
    got_z = rsp_z;
    for (int h = 0; h < hold; h++) begin
      rsp_ack = stray & ~oh;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== oh || rsp_z !== exp_z || busy !== 1'b1 || req_ready !== '0 || mul_z_ack !== 1'b0) begin
        failures++;
        $display("FAIL resp_hold cycle=%0d rsp_valid=%b rsp_z=%h busy=%b ready=%b z_ack=%b expected %b %h 1 0 0",
                 h, rsp_valid, rsp_z, busy, req_ready, mul_z_ack, oh, exp_z);
      end
    end
    rsp_ack = oh;
    @(posedge clk); #1;
    rsp_ack = '0;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL release rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    model_last = exp_g;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    rsp_ack     = '0;
    force_a_ack = 1'b0;
    force_z_stb = 1'b0;
    hold_b_ack  = 1'b0;
    fixed_lat   = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_last = N - 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_z !== '0 || mul_a !== '0 || mul_b !== '0 ||
        mul_a_stb !== 1'b0 || mul_b_stb !== 1'b0 || mul_z_ack !== 1'b0 || busy !== 1'b0 ||
        grant !== '0 || mul_rst !== 1'b1) begin
      failures++;
      $display("FAIL %s ready=%b rsp_valid=%b rsp_z=%h a=%h b=%h stb=%b%b zack=%b busy=%b grant=%0d mul_rst=%b expected all 0, mul_rst=1",
               tag, req_ready, rsp_valid, rsp_z, mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack, busy, grant, mul_rst);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ack   = '0;
    for (int i = 0; i < N; i++) begin
      opa[NL'(i)] = 32'h3F80_0000;
      opb[NL'(i)] = 32'h3F80_0000;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mul_rst !== 1'b0 || req_ready !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release mul_rst=%b req_ready=%b busy=%b expected 0 0 0", mul_rst, req_ready, busy);
    end
    req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_request req_ready=%b busy=%b expected 0 0", req_ready, busy);
    end
    model_last = N - 1;
  endtask

  task automatic test_single();
    int g, lat;
    logic [31:0] z;
    opa[0] = 32'h4000_0000;
    opb[0] = 32'h4040_0000;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 4'b0001 || mul_a_stb !== 1'b1) begin
      failures++;
      $display("FAIL grant_latency req_ready=%b a_stb=%b expected 0001 1 one cycle after request", req_ready, mul_a_stb);
    end
    serve_one(0, '0, 1'b1, 1'b0, g, z, lat);
    checks++;
    if (g != 0 || z !== 32'h40C0_0000) begin
      failures++;
      $display("FAIL single_product grant=%0d rsp_z=%h expected 0 40c00000", g, z);
    end
  endtask

  task automatic test_round_robin();
    int g, lat;
    logic [31:0] z;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) begin
      opa[NL'(i)] = 32'h3FC0_0000;
      opb[NL'(i)] = 32'h3FC0_0000;
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      serve_one(0, '0, 1'b0, 1'b0, g, z, lat);
      checks++;
      if (g != rr_exp[k] || z !== 32'h4010_0000 || (k > 0 && lat != 1)) begin
        failures++;
        $display("FAIL round_robin step=%0d grant=%0d rsp_z=%h gap=%0d expected %0d 40100000 gap 1",
                 k, g, z, lat, rr_exp[k]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_slow_consumer();
    int g, lat;
    logic [31:0] z;
    opa[2] = rand_fp();
    opb[2] = rand_fp();
    req_valid = 4'b0100;
    serve_one(20, '0, 1'b1, 1'b0, g, z, lat);
    req_valid = 4'b1111;
    serve_one(0, '0, 1'b1, 1'b0, g, z, lat);
    checks++;
    if (g != 3) begin
      failures++;
      $display("FAIL after_slow_grant grant=%0d expected 3", g);
    end
    req_valid = '0;
  endtask

  task automatic test_wrong_lane();
    int g, lat;
    logic [31:0] z;
    opa[1] = rand_fp();
    opb[1] = rand_fp();
    req_valid = 4'b0010;
    serve_one(3, 4'b1001, 1'b1, 1'b0, g, z, lat);
    checks++;
    if (g != 1) begin
      failures++;
      $display("FAIL wrong_lane_grant grant=%0d expected 1", g);
    end
  endtask

  task automatic test_stray();
    int t;
    logic [31:0] exp_z;
    req_valid = '0;
    force_z_stb = 1'b1;
    @(posedge clk); #1;
    force_z_stb = 1'b0;
    checks++;
    if (mul_z_ack !== 1'b0 || rsp_valid !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL stray_z_idle z_ack=%b rsp_valid=%b busy=%b ready=%b expected all 0",
               mul_z_ack, rsp_valid, busy, req_ready);
    end
    hold_b_ack = 1'b1;
    opa[0] = rand_fp();
    opb[0] = rand_fp();
    exp_z = fp_mul(opa[0], opb[0]);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    force_a_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mul_b_stb !== 1'b1 || mul_a_stb !== 1'b0 || mul_z_ack !== 1'b0 || rsp_valid !== '0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stray_a_in_send_b cycle=%0d b_stb=%b a_stb=%b z_ack=%b rsp_valid=%b busy=%b expected 1 0 0 0 1",
                 k, mul_b_stb, mul_a_stb, mul_z_ack, rsp_valid, busy);
      end
      @(posedge clk); #1;
    end
    force_a_ack = 1'b0;
    hold_b_ack  = 1'b0;
    t = 0;
    while (rsp_valid == 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_z !== exp_z) begin
      failures++;
      $display("FAIL stray_completion rsp_valid=%b rsp_z=%h after %0d cycles expected 0001 %h", rsp_valid, rsp_z, t, exp_z);
    end
    rsp_ack = 4'b0001;
    @(posedge clk); #1;
    rsp_ack = '0;
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    int t, g, lat;
    logic [31:0] z;
    fixed_lat = 30;
    opa[2] = rand_fp();
    opb[2] = rand_fp();
    req_valid = 4'b0100;
    t = 0;
    while (req_ready == 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || mul_a_stb !== 1'b0 || mul_b_stb !== 1'b0 || rsp_valid !== '0 || grant !== 2'd2) begin
      failures++;
      $display("FAIL wait_z_reached busy=%b stb=%b%b rsp_valid=%b grant=%0d expected 1 00 0 2",
               busy, mul_a_stb, mul_b_stb, rsp_valid, grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    fixed_lat = -1;
    for (int i = 0; i < N; i++) begin
      opa[NL'(i)] = rand_fp();
      opb[NL'(i)] = rand_fp();
    end
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mul_rst !== 1'b0 || req_ready !== '0 || rsp_valid !== '0) begin
      failures++;
      $display("FAIL mid_reset_release mul_rst=%b ready=%b rsp_valid=%b expected 0 0 0", mul_rst, req_ready, rsp_valid);
    end
    model_last = N - 1;
    serve_one(0, '0, 1'b1, 1'b0, g, z, lat);
    checks++;
    if (g != 0) begin
      failures++;
      $display("FAIL first_after_reset grant=%0d expected 0", g);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g, lat;
    logic [31:0] z;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        opa[NL'(i)] = rand_fp();
        opb[NL'(i)] = rand_fp();
      end
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      serve_one(int'($urandom_range(0, 3)), N'($urandom), 1'($urandom), 1'b1, g, z, lat);
    end
    req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_slow_consumer();
    test_wrong_lane();
    test_stray();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
